sram_write_arbiter: RTL and testbench

Two-port write arbiter and sequencer for the shared 64-bit SRAM write port of the canny filter. It accepts word-write requests from two producers (port 0: the normalised-pixel output stage; port 1: a secondary writer such as the raw or debug image path), picks one round-robin, and drives the SRAM with the two-phase protocol: address setup with `we` low, then data with `we` high. It also counts the words written per frame and flags frame completion.

---
 rtl/sram_write_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_write_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_arbiter.sv
// -----------------------------------------------------------------------------
// sram_write_arbiter
//
// Round-robin write arbiter and two-phase sequencer for the shared 64-bit SRAM
// write port of the canny filter. Two producers post word writes; the winner
// is granted with a one-cycle pulse. The SRAM then sees the address in one
// cycle (SETUP, we low) and the data in the next (WRITE, we high). Words
// written are counted per frame, and frameDone pulses when a frame completes.
//
// Optional feature macro: SRAM_ADDR_CHECK_EN
//   When this macro is defined, a winning request whose address is above
//   MAXADDR is granted but dropped, and the sticky addrError flag is set.
//   When it is not defined, every address is written unchecked and
//   addrError is tied to 0.
//
// Parameters
//   MAXADDR     highest legal word address
//   FRAMEWORDS  words per frame, summed over both ports (1 .. 2^20)
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous reset, active low
//   req0/addr0/data0, gnt0   port 0 request, address, data and grant pulse
//   req1/addr1/data1, gnt1   port 1 request, address, data and grant pulse
//   wraddr         SRAM write address (held stable through SETUP and WRITE)
//   outData        SRAM write data (valid during WRITE)
//   we             SRAM write enable, active high
//   busy           high when the sequencer is not idle
//   frameDone      one-cycle pulse after the last word of a frame
//   addrError      sticky out-of-range flag (only with SRAM_ADDR_CHECK_EN)
// -----------------------------------------------------------------------------
module sram_write_arbiter #(
    parameter int unsigned MAXADDR    = 524287,
    parameter int unsigned FRAMEWORDS = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [19:0] addr0,
    input  logic [63:0] data0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [19:0] addr1,
    input  logic [63:0] data1,
    output logic        gnt1,
    output logic [19:0] wraddr,
    output logic [63:0] outData,
    output logic        we,
    output logic        busy,
    output logic        frameDone,
    output logic        addrError
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        WRITE = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        lastGrant_q;
    logic        gnt0_q, gnt1_q;
    logic        we_q;
    logic [19:0] wraddr_q;
    logic [63:0] hold_q;
    logic [19:0] frameCnt_q;
    logic        frameDone_q;

    logic        arb_en;
    logic        req0_eff, req1_eff;
    logic        win0, win1, win_any;
    logic [19:0] win_addr;
    logic [63:0] win_data;
    logic        bad_addr;
    logic [20:0] cnt_inc;
    logic        frame_wrap;

    // A port whose grant is showing this cycle is masked, so a requester that
    // only updates at the end of its grant cycle is never granted twice.
    assign req0_eff = req0 & ~gnt0_q;
    assign req1_eff = req1 & ~gnt1_q;

    // Requests are not looked at in SETUP.
    assign arb_en = (state_q == IDLE) || (state_q == WRITE);

    // On a tie, the port that did not win last time wins now.
    assign win0    = arb_en & req0_eff & (~req1_eff | lastGrant_q);
    assign win1    = arb_en & req1_eff & (~req0_eff | ~lastGrant_q);
    assign win_any = win0 | win1;

    assign win_addr = win1 ? addr1 : addr0;
    assign win_data = win1 ? data1 : data0;

`ifdef SRAM_ADDR_CHECK_EN
    logic addrError_q;

    assign bad_addr  = ({12'd0, win_addr} > 32'(MAXADDR));
    assign addrError = addrError_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            addrError_q <= 1'b0;
        end else if (win_any && bad_addr) begin
            addrError_q <= 1'b1;
        end
    end
`else
    assign bad_addr  = 1'b0;
    assign addrError = 1'b0;
`endif

    // The count is one bit wider so that FRAMEWORDS = 2^20 can be compared.
    assign cnt_inc    = {1'b0, frameCnt_q} + 21'd1;
    assign frame_wrap = (cnt_inc == 21'(FRAMEWORDS));

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE, WRITE: state_d = (win_any && !bad_addr) ? SETUP : IDLE;
            SETUP:       state_d = WRITE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            we_q        <= 1'b0;
            wraddr_q    <= '0;
            hold_q      <= '0;
            frameCnt_q  <= '0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt0_q      <= win0;
            gnt1_q      <= win1;
            // we is high exactly during WRITE, which always follows SETUP.
            we_q        <= (state_q == SETUP);
            frameDone_q <= 1'b0;

            if (win_any) begin
                lastGrant_q <= win1;
            end

            if (win_any && !bad_addr) begin
                wraddr_q <= win_addr;
                hold_q   <= win_data;
            end

            if (state_q == WRITE) begin
                if (frame_wrap) begin
                    frameCnt_q  <= '0;
                    frameDone_q <= 1'b1;
                end else begin
                    frameCnt_q  <= cnt_inc[19:0];
                end
            end
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign we        = we_q;
    assign wraddr    = wraddr_q;
    assign outData   = hold_q;
    assign busy      = (state_q != IDLE);
    assign frameDone = frameDone_q;

endmodule

// File: tb/tb_sram_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_write_arbiter
//
// Directed bench for sram_write_arbiter (FRAMEWORDS = 4). Each expected SRAM
// write is queued when its request is set up. A negedge monitor pops the
// queue on every we cycle, and it tracks the words per frame to predict
// frameDone.
// -----------------------------------------------------------------------------
module tb_sram_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [19:0] addr0, addr1;
    logic [63:0] data0, data1;
    logic        gnt0, gnt1;
    logic [19:0] wraddr;
    logic [63:0] outData;
    logic        we, busy, frameDone, addrError;

    always #5 clk = ~clk;

    sram_write_arbiter #(
        .MAXADDR    (524287),
        .FRAMEWORDS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .addr0     (addr0),
        .data0     (data0),
        .gnt0      (gnt0),
        .req1      (req1),
        .addr1     (addr1),
        .data1     (data1),
        .gnt1      (gnt1),
        .wraddr    (wraddr),
        .outData   (outData),
        .we        (we),
        .busy      (busy),
        .frameDone (frameDone),
        .addrError (addrError)
    );

    typedef struct packed {
        logic [19:0] a;
        logic [63:0] d;
    } wr_t;

    wr_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  wcount      = 0;
    bit  fd_pending  = 1'b0;
    int  fd_count    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input int port, input logic [19:0] a);
        logic [63:0] d;
        d = {44'd0, a};
        return (port != 0) ? ~d : d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic r, input logic [19:0] a);
        if (port == 0) begin
            req0 = r; addr0 = a; data0 = data_of(0, a);
        end else begin
            req1 = r; addr1 = a; data1 = data_of(1, a);
        end
    endtask

    task automatic push(input int port, input logic [19:0] a);
        wr_t e;
        e.a = a;
        e.d = data_of(port, a);
        sb.push_back(e);
    endtask

    // Holds reset low for n edges and checks the reset values after each one.
    task automatic apply_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) begin
                wcount     = 0;
                fd_pending = 1'b0;
                fd_count   = 0;
            end
            chk($sformatf("rst_gnt0_c%0d", i), gnt0, 0);
            chk($sformatf("rst_gnt1_c%0d", i), gnt1, 0);
            chk($sformatf("rst_we_c%0d", i), we, 0);
            chk($sformatf("rst_busy_c%0d", i), busy, 0);
            chk($sformatf("rst_wraddr_c%0d", i), wraddr, 0);
            chk($sformatf("rst_outData_c%0d", i), outData, 0);
            chk($sformatf("rst_addrError_c%0d", i), addrError, 0);
        end
        reset = 1'b1;
    endtask

    // n back-to-back writes from one port, starting with the FSM in IDLE.
    task automatic stream(input int port, input int n, input logic [19:0] base);
        int          k;
        logic [19:0] a;
        k = 0;
        a = base;
        drive(port, 1'b1, a);
        push(port, a);
        for (int i = 0; i < 2 * n; i++) begin
            tick();
            chk($sformatf("p%0d_gnt_c%0d", port, i), (port != 0) ? gnt1 : gnt0, (i % 2 == 0));
            chk($sformatf("p%0d_gnt_other_c%0d", port, i), (port != 0) ? gnt0 : gnt1, 0);
            chk($sformatf("p%0d_we_c%0d", port, i), we, (i % 2));
            chk($sformatf("p%0d_busy_c%0d", port, i), busy, 1);
            if (i % 2 == 0) begin
                k++;
                if (k < n) begin
                    a = base + 20'(k);
                    drive(port, 1'b1, a);
                    push(port, a);
                end else begin
                    drive(port, 1'b0, a);
                end
            end
        end
        tick();
        chk($sformatf("p%0d_end_we", port), we, 0);
        chk($sformatf("p%0d_end_busy", port), busy, 0);
    endtask

    // Scoreboard side: one pop per we cycle, plus the frame-completion model.
    always @(negedge clk) begin
        wr_t e;
        chk("frameDone", frameDone, fd_pending);
        if (frameDone === 1'b1) fd_count++;
        fd_pending = 1'b0;
        if (we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("we_without_request", we, 0);
            end else begin
                e = sb.pop_front();
                chk("wraddr", wraddr, e.a);
                chk("outData", outData, e.d);
                wcount++;
                if (wcount == 4) begin
                    wcount     = 0;
                    fd_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        req1  = 1'b0; addr1 = '0; data1 = '0;
        drive(0, 1'b1, 20'h00005);

        // Reset held with a request pending: nothing may be granted.
        apply_reset(3);

        // Release: grant in the first cycle, we in the second.
        push(0, 20'h00005);
        tick();
        chk("rel_gnt0", gnt0, 1);
        chk("rel_we0", we, 0);
        chk("rel_wraddr", wraddr, 20'h00005);
        drive(0, 1'b0, 20'h00005);
        tick();
        chk("rel_we1", we, 1);
        chk("rel_gnt0_off", gnt0, 0);
        tick();
        chk("rel_idle", busy, 0);

        // Single port, continuous, addresses 0..3.
        stream(0, 4, 20'h00000);

        // Reset between grant and write: the write is aborted.
        drive(0, 1'b1, 20'h00007);
        tick();
        chk("abort_gnt0", gnt0, 1);
        drive(0, 1'b0, 20'h00007);
        apply_reset(1);

        // Contention: grants alternate, port 0 first after reset.
        push(0, 20'h00100);
        push(1, 20'h00200);
        push(0, 20'h00101);
        push(1, 20'h00201);
        drive(0, 1'b1, 20'h00100);
        drive(1, 1'b1, 20'h00200);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("arb_gnt0_c%0d", i), gnt0, (i % 2 == 0) && ((i / 2) % 2 == 0));
            chk($sformatf("arb_gnt1_c%0d", i), gnt1, (i % 2 == 0) && ((i / 2) % 2 == 1));
            chk($sformatf("arb_we_c%0d", i), we, (i % 2));
            if (i == 0) drive(0, 1'b1, 20'h00101);
            if (i == 2) drive(1, 1'b1, 20'h00201);
            if (i == 4) drive(0, 1'b0, 20'h00101);
            if (i == 6) drive(1, 1'b0, 20'h00201);
        end
        tick();
        chk("arb_end_busy", busy, 0);

        // Frame: 5 port-1 writes from a fresh counter give one frameDone.
        apply_reset(1);
        stream(1, 5, 20'h00A00);
        tick();
        chk("frame_pulses", fd_count, 1);

        // Idle gap between two single writes.
        stream(0, 1, 20'h0003A);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("gap_busy_c%0d", i), busy, 0);
            chk($sformatf("gap_we_c%0d", i), we, 0);
        end
        stream(0, 1, 20'h0003B);

`ifdef SRAM_ADDR_CHECK_EN
        // Out-of-range address: granted, dropped, flagged.
        drive(0, 1'b1, 20'h80000);
        tick();
        chk("bad_gnt0", gnt0, 1);
        chk("bad_busy", busy, 0);
        chk("bad_we", we, 0);
        chk("bad_err", addrError, 1);
        drive(0, 1'b0, 20'h80000);
        tick();
        chk("bad_gnt0_off", gnt0, 0);
        chk("bad_we2", we, 0);
        chk("bad_err2", addrError, 1);
        stream(0, 1, 20'h00044);
        chk("bad_err_sticky", addrError, 1);
`else
        // Without the check, an address above MAXADDR is simply written.
        stream(0, 1, 20'h80000);
        chk("nochk_err", addrError, 0);
`endif

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
